// File: rtl/key_set_ctrl_if.sv
// key_set_ctrl_if: key pulses in, field select / adjust / blink / done out
interface key_set_ctrl_if;
  logic       key_mode;
  logic       key_up;
  logic       key_down;
  logic       tick_1hz;
  logic [1:0] sel;
  logic       adj_inc;
  logic       adj_dec;
  logic       blink;
  logic       set_done;
  modport master (
    output key_mode, key_up, key_down, tick_1hz,
    input  sel, adj_inc, adj_dec, blink, set_done
  );
  modport slave (
    input  key_mode, key_up, key_down, tick_1hz,
    output sel, adj_inc, adj_dec, blink, set_done
  );
endinterface

// File: rtl/key_set_ctrl.sv
// key_set_ctrl: time-setting FSM driven by debounced key pulses with idle timeout.
// Define SET_SEC_EN to include the SET_SEC field; otherwise SET_MIN returns to RUN.
module key_set_ctrl #(
  parameter int TIMEOUT_S = 10,
  parameter int TO_W      = 8
) (
  input  logic         clk,
  input  logic         rst,
  key_set_ctrl_if.slave k
);
  localparam logic [1:0] RUN     = 2'd0;
  localparam logic [1:0] SET_HR  = 2'd1;
  localparam logic [1:0] SET_MIN = 2'd2;
`ifdef SET_SEC_EN
  localparam logic [1:0] SET_SEC = 2'd3;
  localparam logic [1:0] MIN_NXT = SET_SEC;
`else
  localparam logic [1:0] MIN_NXT = RUN;
`endif
  localparam logic [TO_W:0] TMAX = (TO_W+1)'(TIMEOUT_S);
  logic [1:0]      st, nxt, mode_nxt;
  logic [TO_W-1:0] cnt;
  logic            set, key, tmo, adj_up, adj_dn;
  assign set      = st != RUN;
  assign key      = k.key_mode | k.key_up | k.key_down;
  assign tmo      = set && k.tick_1hz && !key && ({1'b0, cnt} + (TO_W+1)'(1) == TMAX);
  assign mode_nxt = st == RUN ? SET_HR : st == SET_HR ? SET_MIN : st == SET_MIN ? MIN_NXT : RUN;
  assign nxt      = k.key_mode ? mode_nxt : tmo ? RUN : st;
  assign adj_up   = set && k.key_up && !k.key_down && !k.key_mode;
  assign adj_dn   = set && k.key_down && !k.key_up && !k.key_mode;
  assign k.sel    = st;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st         <= RUN;
      cnt        <= '0;
      k.adj_inc  <= 1'b0;
      k.adj_dec  <= 1'b0;
      k.blink    <= 1'b0;
      k.set_done <= 1'b0;
    end else begin
      st         <= nxt;
      cnt        <= (key || tmo || !set) ? '0 : (k.tick_1hz && cnt != '1) ? cnt + TO_W'(1) : cnt;
      k.adj_inc  <= adj_up;
      k.adj_dec  <= adj_dn;
      k.set_done <= set && nxt == RUN;
      // blank phase is suppressed right after an adjust so the new value shows
      k.blink    <= (nxt == RUN || adj_up || adj_dn) ? 1'b0 : (set && k.tick_1hz) ? ~k.blink : k.blink;
    end
  end
endmodule

// File: tb/tb_key_set_ctrl.sv
// tb_key_set_ctrl: vector table plus timeout/reset sequences, scoreboard-checked.
module tb_key_set_ctrl;
  typedef struct packed {
    logic [1:0] sel;
    logic       inc;
    logic       dec;
    logic       blink;
    logic       done;
  } out_t;
  typedef struct {
    logic m, u, d, t;
    out_t e;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  out_t sb[$];
  vec_t vec[$];
  key_set_ctrl_if kif();
  key_set_ctrl #(.TIMEOUT_S(10), .TO_W(8)) dut (.clk(clk), .rst(rst), .k(kif));
  always #5 clk = ~clk;
  function automatic out_t cur();
    return '{kif.sel, kif.adj_inc, kif.adj_dec, kif.blink, kif.set_done};
  endfunction
  task automatic chk(input string name, input out_t got, input out_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got sel=%0d inc=%b dec=%b blink=%b done=%b want sel=%0d inc=%b dec=%b blink=%b done=%b",
               name, got.sel, got.inc, got.dec, got.blink, got.done,
               exp.sel, exp.inc, exp.dec, exp.blink, exp.done);
    end
  endtask
  task automatic step(input string name, input logic m, u, d, t, input out_t e);
    out_t g, x;
    kif.key_mode = m; kif.key_up = u; kif.key_down = d; kif.tick_1hz = t;
    sb.push_back(e);
    @(posedge clk); #1;
    kif.key_mode = 0; kif.key_up = 0; kif.key_down = 0; kif.tick_1hz = 0;
    g = cur();
    x = sb.pop_front();
    chk(name, g, x);
    checks++;
    if (g.inc && g.dec) begin
      failures++;
      $display("FAIL %s adj_inc and adj_dec both high", name);
    end
  endtask
  initial begin
    kif.key_mode = 0; kif.key_up = 0; kif.key_down = 0; kif.tick_1hz = 0;
    // {m,u,d,t} -> {sel,inc,dec,blink,done} seen after the edge
    vec.push_back('{0,0,0,0, '{2'd0,0,0,0,0}});
    vec.push_back('{0,1,0,0, '{2'd0,0,0,0,0}});
    vec.push_back('{0,0,1,1, '{2'd0,0,0,0,0}});
    vec.push_back('{1,0,0,0, '{2'd1,0,0,0,0}});
    vec.push_back('{0,1,0,0, '{2'd1,1,0,0,0}});
    vec.push_back('{0,0,0,0, '{2'd1,0,0,0,0}});
    vec.push_back('{0,1,0,0, '{2'd1,1,0,0,0}});
    vec.push_back('{0,1,0,0, '{2'd1,1,0,0,0}});
    vec.push_back('{0,0,0,0, '{2'd1,0,0,0,0}});
    vec.push_back('{0,1,1,0, '{2'd1,0,0,0,0}});
    vec.push_back('{0,0,0,1, '{2'd1,0,0,1,0}});
    vec.push_back('{0,0,1,0, '{2'd1,0,1,0,0}});
    vec.push_back('{0,0,0,1, '{2'd1,0,0,1,0}});
    vec.push_back('{0,0,0,1, '{2'd1,0,0,0,0}});
    vec.push_back('{0,0,0,1, '{2'd1,0,0,1,0}});
    vec.push_back('{1,0,1,0, '{2'd2,0,0,1,0}});
    vec.push_back('{0,0,0,1, '{2'd2,0,0,0,0}});
`ifdef SET_SEC_EN
    vec.push_back('{1,0,0,0, '{2'd3,0,0,0,0}});
    vec.push_back('{0,0,1,0, '{2'd3,0,1,0,0}});
`endif
    vec.push_back('{1,0,0,0, '{2'd0,0,0,0,0}});
    vec[vec.size()-1].e.done = 1'b1;
    vec.push_back('{0,0,0,0, '{2'd0,0,0,0,0}});
    #3 rst = 1'b0;
    #1 chk("reset_async", cur(), '{2'd0,0,0,0,0});
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < vec.size(); i++)
      step($sformatf("vec%0d", i), vec[i].m, vec[i].u, vec[i].d, vec[i].t, vec[i].e);
    step("to_hr", 1,0,0,0, '{2'd1,0,0,0,0});
    step("to_min", 1,0,0,0, '{2'd2,0,0,0,0});
    for (int i = 1; i <= 10; i++) begin
      step($sformatf("tmo_tick%0d", i), 0,0,0,1,
           '{(i < 10) ? 2'd2 : 2'd0, 1'b0, 1'b0, (i < 10) ? 1'(i % 2) : 1'b0, 1'(i == 10)});
      step($sformatf("tmo_idle%0d", i), 0,0,0,0,
           '{(i < 10) ? 2'd2 : 2'd0, 1'b0, 1'b0, (i < 10) ? 1'(i % 2) : 1'b0, 1'b0});
    end
    step("b_hr", 1,0,0,0, '{2'd1,0,0,0,0});
    step("b_min", 1,0,0,0, '{2'd2,0,0,0,0});
    for (int i = 1; i <= 8; i++)
      step($sformatf("b_tick%0d", i), 0,0,0,1, '{2'd2, 1'b0, 1'b0, 1'(i % 2), 1'b0});
    step("b_tick9_up", 0,1,0,1, '{2'd2,1,0,0,0});
    for (int i = 1; i <= 10; i++)
      step($sformatf("b_after%0d", i), 0,0,0,1,
           '{(i < 10) ? 2'd2 : 2'd0, 1'b0, 1'b0, (i < 10) ? 1'(i % 2) : 1'b0, 1'(i == 10)});
    step("c_hr", 1,0,0,0, '{2'd1,0,0,0,0});
    step("c_tick", 0,0,0,1, '{2'd1,0,0,1,0});
    rst = 1'b0;
    #1 chk("c_rst_async", cur(), '{2'd0,0,0,0,0});
    @(posedge clk); #1 rst = 1'b1;
    step("c_no_done", 0,0,0,0, '{2'd0,0,0,0,0});
    step("c_run_tick1", 0,0,0,1, '{2'd0,0,0,0,0});
    step("c_run_tick2", 0,0,0,1, '{2'd0,0,0,0,0});
    step("c_hr2", 1,0,0,0, '{2'd1,0,0,0,0});
    step("c_hr_tick", 0,0,0,1, '{2'd1,0,0,1,0});
    step("c_min", 1,0,0,0, '{2'd2,0,0,1,0});
`ifdef SET_SEC_EN
    step("c_sec", 1,0,0,0, '{2'd3,0,0,1,0});
`endif
    step("c_exit", 1,0,0,0, '{2'd0,0,0,0,1});
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_empty got %0d pending want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
